scan_multiplexer: RTL and testbench

//   Parametrised N-channel, W-bit registered multiplexer with two modes.
//   - Manual: the Sel port chooses the channel.
//   - Auto-scan: an internal counter steps through the channels, holding each for DWELL cycles.

---
 rtl/scan_multiplexer.sv | 143 ++++++++++++++
 tb/tb_scan_multiplexer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/scan_multiplexer.sv
// scan_multiplexer
//   N-channel, W-bit registered multiplexer with manual select and auto-scan.
//   In scan mode an internal index steps through the channels, holding each
//   one for DWELL edges. Din is resampled on every edge, so a change within a
//   dwell period shows up on y_o one edge later.
//
//   Ports
//     clk_i    rising-edge clock
//     rst_n_i  asynchronous active-low reset
//     en_i     1 = run, 0 = freeze (outputs hold, valid_o = 0)
//     mode_i   0 = manual select, 1 = auto-scan
//     sel_i    manual channel select (ignored in scan and while frozen)
//     din_i    packed channel data, channel i = din_i[i*WIDTH +: WIDTH]
//     y_o      registered selected data
//     ch_o     index of the channel currently on y_o
//     valid_o  y_o / ch_o qualified this cycle
//     wrap_o   one-cycle pulse on the edge where ch_o goes CH-1 -> 0
//
//   state    | meaning
//   ST_IDLE  | frozen: data/index/dwell hold, valid_o = 0
//   ST_MAN   | manual select from sel_i
//   ST_SCAN  | auto-scan through channels, DWELL edges each
module scan_multiplexer #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [CH*WIDTH-1:0]   din_i,
    output logic [WIDTH-1:0]      y_o,
    output logic [SEL_W-1:0]      ch_o,
    output logic                  valid_o,
    output logic                  wrap_o
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    // Set when idx wraps CH-1 -> 0; the edge that then presents channel 0
    // raises wrap_o. Survives a freeze so a resume still reports the wrap.
    logic               wrap_pend_q;
    logic [WIDTH-1:0]   y_q;
    logic [SEL_W-1:0]   ch_q;
    logic               valid_q;
    logic               wrap_q;

    logic [WIDTH-1:0]   sel_data;
    logic [WIDTH-1:0]   idx_data;
    logic               sel_ok;
    logic               last_cnt;
    logic               last_idx;

    // Explicit decode so out-of-range selects (CH not a power of two) never
    // index past the packed input.
    always_comb begin
        sel_data = '0;
        idx_data = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (sel_i == SEL_W'(i)) begin
                sel_data = din_i[i*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
            if (idx_q == SEL_W'(i)) begin
                idx_data = din_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign last_cnt = (cnt_q == CNT_W'(DWELL - 1));
    assign last_idx = (idx_q == SEL_W'(CH - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            wrap_pend_q <= 1'b0;
            y_q         <= '0;
            ch_q        <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
        end else if (!en_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (!mode_i) begin
            state_q <= ST_MAN;
            wrap_q  <= 1'b0;
            // Entering manual discards scan progress; next scan starts at 0.
            if (state_q != ST_MAN) begin
                idx_q       <= '0;
                cnt_q       <= '0;
                wrap_pend_q <= 1'b0;
            end
            if (sel_ok) begin
                y_q     <= sel_data;
                ch_q    <= sel_i;
                valid_q <= 1'b1;
            end else begin
                y_q     <= '0;
                valid_q <= 1'b0;
            end
        end else begin
            state_q     <= ST_SCAN;
            y_q         <= idx_data;
            ch_q        <= idx_q;
            valid_q     <= 1'b1;
            wrap_q      <= wrap_pend_q;
            wrap_pend_q <= 1'b0;
            if (last_cnt) begin
                cnt_q <= '0;
                if (last_idx) begin
                    idx_q       <= '0;
                    wrap_pend_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign y_o     = y_q;
    assign ch_o    = ch_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_scan_multiplexer.sv
module tb_scan_multiplexer;

    logic        clk;
    logic        rst_n;

    // CH=4, DWELL=2 instance
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [7:0]  y;
    logic [1:0]  ch;
    logic        valid;
    logic        wrap;

    // CH=3, DWELL=1 instance
    logic        en3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] din3;
    logic [7:0]  y3;
    logic [1:0]  ch3;
    logic        valid3;
    logic        wrap3;

    int total = 0;
    int bad   = 0;

    scan_multiplexer #(.WIDTH(8), .CH(4), .SEL_W(2), .DWELL(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode), .sel_i(sel),
        .din_i(din), .y_o(y), .ch_o(ch), .valid_o(valid), .wrap_o(wrap)
    );

    scan_multiplexer #(.WIDTH(8), .CH(3), .SEL_W(2), .DWELL(1)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en3), .mode_i(mode3), .sel_i(sel3),
        .din_i(din3), .y_o(y3), .ch_o(ch3), .valid_o(valid3), .wrap_o(wrap3)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic [1:0] ech,
                           input logic ev, input logic ew);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".ch"}, {6'd0, ch}, {6'd0, ech});
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
        chk({tag, ".wrap"}, {7'd0, wrap}, {7'd0, ew});
    endtask

    logic [1:0] exp_ch [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [7:0] exp_y  [9] = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hAA};
    logic [1:0] exp_ch3 [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [7:0] exp_y3  [5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};

    initial begin
        rst_n = 1'b1;
        en = 1'b0; mode = 1'b0; sel = 2'd0; din = 32'hDDCCBBAA;
        en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; din3 = 24'h332211;

        // 1. async reset between edges
        #5 rst_n = 1'b0;
        #1;
        chk_out("rst_async", 8'h00, 2'd0, 1'b0, 1'b0);
        step();
        chk_out("rst_held", 8'h00, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        en = 1'b1; mode = 1'b0; sel = 2'd2;
        #1;
        chk_out("rst_release", 8'h00, 2'd0, 1'b0, 1'b0);

        // 2. manual select
        step();
        chk_out("man_sel2", 8'hCC, 2'd2, 1'b1, 1'b0);
        sel = 2'd3;
        step();
        chk_out("man_sel3", 8'hDD, 2'd3, 1'b1, 1'b0);

        // 3. scan entry from manual, full cycle with wrap
        mode = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk_out($sformatf("scan_e%0d", k + 1), exp_y[k], exp_ch[k], 1'b1, (k == 8));
        end

        // 4. freeze after first ch=1 edge
        mode = 1'b0; sel = 2'd0;
        step();
        chk_out("man_sel0", 8'hAA, 2'd0, 1'b1, 1'b0);
        mode = 1'b1;
        step();
        chk_out("frz_e1", 8'hAA, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("frz_e2", 8'hAA, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("frz_e3", 8'hBB, 2'd1, 1'b1, 1'b0);
        en = 1'b0;
        sel = 2'd3; mode = 1'b0;   // ignored while frozen
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("frozen%0d", k), 8'hBB, 2'd1, 1'b0, 1'b0);
        end
        en = 1'b1; mode = 1'b1;
        step();
        chk_out("resume_ch1", 8'hBB, 2'd1, 1'b1, 1'b0);
        step();
        chk_out("resume_ch2", 8'hCC, 2'd2, 1'b1, 1'b0);

        // Din change mid-dwell appears on the next edge
        din = 32'hDD5ABBAA;
        step();
        chk_out("din_resample", 8'h5A, 2'd2, 1'b1, 1'b0);
        din = 32'hDDCCBBAA;

        // 6. async reset mid-scan, then restart with a full dwell
        #3 rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 8'h00, 2'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        step();
        chk_out("rst_scan_e1", 8'hAA, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("rst_scan_e2", 8'hAA, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("rst_scan_e3", 8'hBB, 2'd1, 1'b1, 1'b0);
        mode = 1'b0; sel = 2'd1;
        step();
        chk_out("man_mid", 8'hBB, 2'd1, 1'b1, 1'b0);
        mode = 1'b1;
        step();
        chk_out("rescan_e1", 8'hAA, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("rescan_e2", 8'hAA, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("rescan_e3", 8'hBB, 2'd1, 1'b1, 1'b0);

        // 5. CH=3, DWELL=1 instance
        en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1;
        step();
        chk("c3_sel1.y", y3, 8'h22);
        chk("c3_sel1.ch", {6'd0, ch3}, 8'd1);
        chk("c3_sel1.valid", {7'd0, valid3}, 8'd1);
        sel3 = 2'd3;
        step();
        chk("c3_sel3.y", y3, 8'h00);
        chk("c3_sel3.ch", {6'd0, ch3}, 8'd1);
        chk("c3_sel3.valid", {7'd0, valid3}, 8'd0);
        mode3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("c3_scan%0d.y", k + 1), y3, exp_y3[k]);
            chk($sformatf("c3_scan%0d.ch", k + 1), {6'd0, ch3}, {6'd0, exp_ch3[k]});
            chk($sformatf("c3_scan%0d.valid", k + 1), {7'd0, valid3}, 8'd1);
            chk($sformatf("c3_scan%0d.wrap", k + 1), {7'd0, wrap3}, {7'd0, (k == 3)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
